// File: rtl/operand_fwd_stage_pkg.sv
// Shared opcode/funct encodings and operand source decode for the ID-stage operand generator.
// The encodings are the ones already used by the pipeline; no new values are introduced here.
package operand_fwd_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;

  typedef enum logic [1:0] {
    OP1_ZERO,
    OP1_RS,
    OP1_LINK
  } op1_sel_t;

  typedef enum logic [2:0] {
    OP2_ZERO,
    OP2_RT,
    OP2_SIGN,
    OP2_ZEXT,
    OP2_HI
  } op2_sel_t;

  typedef struct packed {
    op1_sel_t op1;
    op2_sel_t op2;
  } src_sel_t;

  function automatic src_sel_t decode_src(input logic [5:0] op, input logic [5:0] funct);
    src_sel_t s;
    s.op1 = OP1_ZERO;
    s.op2 = OP2_ZERO;
    case (op)
      OP_SPECIAL: begin
        s.op1 = (funct == FUNCT_JALR) ? OP1_LINK : OP1_RS;
        s.op2 = OP2_RT;
      end
      OP_JAL: s.op1 = OP1_LINK;
      OP_ADDIU, OP_LB, OP_LW, OP_LBU, OP_SB, OP_SH, OP_SW: begin
        s.op1 = OP1_RS;
        s.op2 = OP2_SIGN;
      end
      OP_LUI: begin
        s.op1 = OP1_RS;
        s.op2 = OP2_HI;
      end
      OP_ANDI, OP_ORI: begin
        s.op1 = OP1_RS;
        s.op2 = OP2_ZEXT;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Picks the youngest matching forwarding source for one register index, else the regfile data.
// Purely combinational; match_is_load flags that the winning source has no data yet.
module operand_fwd_mux #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FWD_PORTS      = 2
) (
  input  logic [REG_ADDR_WIDTH-1:0]           src,
  input  logic [DATA_WIDTH-1:0]               reg_data,
  input  logic [FWD_PORTS-1:0]                fwd_valid,
  input  logic [FWD_PORTS-1:0]                fwd_is_load,
  input  logic [FWD_PORTS*REG_ADDR_WIDTH-1:0] fwd_waddr,
  input  logic [FWD_PORTS*DATA_WIDTH-1:0]     fwd_data,
  output logic [DATA_WIDTH-1:0]               data,
  output logic                                match_is_load
);

  // Scan oldest to youngest so the lowest matching index overwrites last and wins.
  always_comb begin
    data          = reg_data;
    match_is_load = 1'b0;
    for (int i = FWD_PORTS - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (src != '0) &&
          (fwd_waddr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == src)) begin
        data          = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
        match_is_load = fwd_is_load[i];
      end
    end
  end

endmodule

// File: rtl/operand_fwd_stage.sv
// ID-stage operand generator with forwarding, load-use stall request and a registered ID/EX output.
// One cycle latency; stall_in holds the outputs, flush and load-use hazards insert bubbles.
module operand_fwd_stage
  import operand_fwd_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FWD_PORTS      = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [ADDR_WIDTH-1:0]               addr,
  input  logic [5:0]                          op,
  input  logic [5:0]                          funct,
  input  logic [15:0]                         imm,
  input  logic [REG_ADDR_WIDTH-1:0]           rs_addr,
  input  logic [REG_ADDR_WIDTH-1:0]           rt_addr,
  input  logic [DATA_WIDTH-1:0]               reg_data_1,
  input  logic [DATA_WIDTH-1:0]               reg_data_2,
  input  logic [FWD_PORTS-1:0]                fwd_valid,
  input  logic [FWD_PORTS-1:0]                fwd_is_load,
  input  logic [FWD_PORTS*REG_ADDR_WIDTH-1:0] fwd_waddr,
  input  logic [FWD_PORTS*DATA_WIDTH-1:0]     fwd_data,
  input  logic                                stall_in,
  input  logic                                flush,
  output logic                                stall_req,
  output logic                                out_valid,
  output logic [DATA_WIDTH-1:0]               operand_1,
  output logic [DATA_WIDTH-1:0]               operand_2
);

  src_sel_t              sel;
  logic [DATA_WIDTH-1:0] sign_ext, zero_ext, hi_ext, link;
  logic [31:0]           hi32;
  logic [ADDR_WIDTH-1:0] link_addr;
  logic [DATA_WIDTH-1:0] rs_data, rt_data;
  logic                  rs_load, rt_load;
  logic                  hazard;
  logic [DATA_WIDTH-1:0] op1_next, op2_next;

  assign sel       = decode_src(op, funct);
  assign sign_ext  = DATA_WIDTH'($signed(imm));
  assign zero_ext  = DATA_WIDTH'(imm);
  assign hi32      = {imm, 16'h0000};
  assign hi_ext    = DATA_WIDTH'(hi32);
  assign link_addr = addr + ADDR_WIDTH'(8);
  assign link      = DATA_WIDTH'(link_addr);

  operand_fwd_mux #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .FWD_PORTS(FWD_PORTS)
  ) u_rs_mux (
    .src(rs_addr), .reg_data(reg_data_1),
    .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load),
    .fwd_waddr(fwd_waddr), .fwd_data(fwd_data),
    .data(rs_data), .match_is_load(rs_load)
  );

  operand_fwd_mux #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .FWD_PORTS(FWD_PORTS)
  ) u_rt_mux (
    .src(rt_addr), .reg_data(reg_data_2),
    .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load),
    .fwd_waddr(fwd_waddr), .fwd_data(fwd_data),
    .data(rt_data), .match_is_load(rt_load)
  );

  always_comb begin
    op1_next = '0;
    case (sel.op1)
      OP1_RS:   op1_next = rs_data;
      OP1_LINK: op1_next = link;
      default:  op1_next = '0;
    endcase
  end

  always_comb begin
    op2_next = '0;
    case (sel.op2)
      OP2_RT:   op2_next = rt_data;
      OP2_SIGN: op2_next = sign_ext;
      OP2_ZEXT: op2_next = zero_ext;
      OP2_HI:   op2_next = hi_ext;
      default:  op2_next = '0;
    endcase
  end

  // Only sources that actually feed an operand can cause a load-use hazard.
  assign hazard    = ((sel.op1 == OP1_RS) && rs_load) || ((sel.op2 == OP2_RT) && rt_load);
  assign stall_req = in_valid && hazard && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      operand_1 <= '0;
      operand_2 <= '0;
    end else if (stall_in) begin
      out_valid <= out_valid;
      operand_1 <= operand_1;
      operand_2 <= operand_2;
    end else if (hazard && in_valid) begin
      out_valid <= 1'b0;
      operand_1 <= '0;
      operand_2 <= '0;
    end else begin
      out_valid <= in_valid;
      operand_1 <= in_valid ? op1_next : '0;
      operand_2 <= in_valid ? op2_next : '0;
    end
  end

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Directed-vector bench: stimulus pushes hand-computed ID/EX results into a queue,
// a monitor pops and compares one entry after every clock edge.
module tb_operand_fwd_stage;
  import operand_fwd_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] addr = '0;
  logic [5:0]  op = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] reg_data_1 = '0;
  logic [31:0] reg_data_2 = '0;
  logic [1:0]  fwd_valid = '0;
  logic [1:0]  fwd_is_load = '0;
  logic [9:0]  fwd_waddr = '0;
  logic [63:0] fwd_data = '0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic        stall_req;
  logic        out_valid;
  logic [31:0] operand_1;
  logic [31:0] operand_2;

  operand_fwd_stage #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .FWD_PORTS(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .addr(addr), .op(op), .funct(funct),
    .imm(imm), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .reg_data_1(reg_data_1), .reg_data_2(reg_data_2),
    .fwd_valid(fwd_valid), .fwd_is_load(fwd_is_load),
    .fwd_waddr(fwd_waddr), .fwd_data(fwd_data),
    .stall_in(stall_in), .flush(flush), .stall_req(stall_req),
    .out_valid(out_valid), .operand_1(operand_1), .operand_2(operand_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, in_valid, stall_in, flush;
    logic [31:0] addr;
    logic [5:0]  op, funct;
    logic [15:0] imm;
    logic [4:0]  rs, rt;
    logic [31:0] rd1, rd2;
    logic [1:0]  fv, fl;
    logic [4:0]  fa0, fa1;
    logic [31:0] fd0, fd1;
    logic        es, ev;
    logic [31:0] e1, e2;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] o1, o2;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic [15:0] im,
                              input logic [4:0] s, input logic [4:0] t,
                              input logic [31:0] d1, input logic [31:0] d2);
    vec_t v;
    v = '{default: '0};
    v.in_valid = 1'b1;
    v.op = o; v.funct = f; v.imm = im; v.rs = s; v.rt = t; v.rd1 = d1; v.rd2 = d2;
    return v;
  endfunction

  function automatic vec_t ex(input vec_t vi, input logic es, input logic ev,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v = vi;
    v.es = es; v.ev = ev; v.e1 = e1; v.e2 = e2;
    return v;
  endfunction

  task automatic go(input string nm, input vec_t v);
    @(negedge clk);
    rst = v.rst; in_valid = v.in_valid; stall_in = v.stall_in; flush = v.flush;
    addr = v.addr; op = v.op; funct = v.funct; imm = v.imm;
    rs_addr = v.rs; rt_addr = v.rt; reg_data_1 = v.rd1; reg_data_2 = v.rd2;
    fwd_valid = v.fv; fwd_is_load = v.fl;
    fwd_waddr = {v.fa1, v.fa0};
    fwd_data  = {v.fd1, v.fd0};
    #1;
    chk({nm, " stall_req"}, 32'(stall_req), 32'(v.es));
    exp_q.push_back('{v.ev, v.e1, v.e2});
    name_q.push_back(nm);
  endtask

  exp_t  mon_e;
  string mon_n;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      chk({mon_n, " out_valid"}, 32'(out_valid), 32'(mon_e.v));
      chk({mon_n, " operand_1"}, operand_1, mon_e.o1);
      chk({mon_n, " operand_2"}, operand_2, mon_e.o2);
    end
  end

  vec_t v, lu, hold;

  initial begin
    v = mk(OP_ADDIU, 6'h0, 16'h0001, 5'd3, 5'd0, 32'd5, 32'd0);
    v.rst = 1'b1;
    go("reset0", ex(v, 1'b0, 1'b0, 32'h0, 32'h0));
    go("reset1", ex(v, 1'b0, 1'b0, 32'h0, 32'h0));

    v = mk(OP_ADDIU, 6'h0, 16'hFFF0, 5'd3, 5'd0, 32'd10, 32'd0);
    go("addiu", ex(v, 1'b0, 1'b1, 32'd10, 32'hFFFF_FFF0));

    v = mk(OP_SPECIAL, FUNCT_ADDU, 16'h0, 5'd4, 5'd5, 32'h99, 32'h77);
    v.fv = 2'b11; v.fa0 = 5'd4; v.fd0 = 32'h11; v.fa1 = 5'd5; v.fd1 = 32'h33;
    go("fwd_both", ex(v, 1'b0, 1'b1, 32'h11, 32'h33));
    v.fa1 = 5'd4; v.fd1 = 32'h22;
    go("fwd_prio", ex(v, 1'b0, 1'b1, 32'h11, 32'h77));
    v.fv = 2'b10;
    go("fwd_old", ex(v, 1'b0, 1'b1, 32'h22, 32'h77));

    lu = mk(OP_SPECIAL, FUNCT_ADDU, 16'h0, 5'd7, 5'd2, 32'h1, 32'h2);
    lu.fv = 2'b01; lu.fl = 2'b01; lu.fa0 = 5'd7; lu.fd0 = 32'hDEAD;
    go("loaduse_rs", ex(lu, 1'b1, 1'b0, 32'h0, 32'h0));
    v = mk(OP_SPECIAL, FUNCT_ADDU, 16'h0, 5'd7, 5'd2, 32'h1, 32'h2);
    v.fv = 2'b10; v.fa1 = 5'd7; v.fd1 = 32'h55;
    go("loaduse_fwd", ex(v, 1'b0, 1'b1, 32'h55, 32'h2));
    v = mk(OP_SPECIAL, FUNCT_ADDU, 16'h0, 5'd1, 5'd7, 32'h1, 32'h2);
    v.fv = 2'b01; v.fl = 2'b01; v.fa0 = 5'd7;
    go("loaduse_rt", ex(v, 1'b1, 1'b0, 32'h0, 32'h0));
    v = mk(OP_ADDIU, 6'h0, 16'h0004, 5'd1, 5'd7, 32'h1, 32'h2);
    v.fv = 2'b01; v.fl = 2'b01; v.fa0 = 5'd7;
    go("unused_rt", ex(v, 1'b0, 1'b1, 32'h1, 32'h4));

    v = mk(OP_SPECIAL, FUNCT_ADDU, 16'h0, 5'd0, 5'd0, 32'hAB, 32'hCD);
    v.fv = 2'b01; v.fl = 2'b01; v.fa0 = 5'd0; v.fd0 = 32'hEE;
    go("reg0", ex(v, 1'b0, 1'b1, 32'hAB, 32'hCD));

    v = mk(OP_JAL, 6'h0, 16'h0, 5'd3, 5'd0, 32'h77, 32'h0); v.addr = 32'h100;
    go("jal", ex(v, 1'b0, 1'b1, 32'h108, 32'h0));
    v = mk(OP_SPECIAL, FUNCT_JALR, 16'h0, 5'd3, 5'd4, 32'h77, 32'h44); v.addr = 32'h200;
    go("jalr", ex(v, 1'b0, 1'b1, 32'h208, 32'h44));
    v = mk(OP_LUI, 6'h0, 16'h1234, 5'd2, 5'd0, 32'h5, 32'h0);
    go("lui", ex(v, 1'b0, 1'b1, 32'h5, 32'h1234_0000));
    v = mk(OP_ORI, 6'h0, 16'h8000, 5'd2, 5'd0, 32'h6, 32'h0);
    go("ori", ex(v, 1'b0, 1'b1, 32'h6, 32'h0000_8000));
    v = mk(OP_ANDI, 6'h0, 16'hFFFF, 5'd2, 5'd0, 32'h6, 32'h0);
    go("andi", ex(v, 1'b0, 1'b1, 32'h6, 32'h0000_FFFF));
    v = mk(OP_LW, 6'h0, 16'h8004, 5'd2, 5'd0, 32'h1000, 32'h0);
    go("lw", ex(v, 1'b0, 1'b1, 32'h1000, 32'hFFFF_8004));
    v = mk(OP_SW, 6'h0, 16'h0010, 5'd2, 5'd9, 32'h2000, 32'h9);
    go("sw", ex(v, 1'b0, 1'b1, 32'h2000, 32'h10));
    v = mk(6'h04, 6'h0, 16'h0003, 5'd2, 5'd3, 32'h9, 32'h9);
    go("other_op", ex(v, 1'b0, 1'b1, 32'h0, 32'h0));

    v = mk(OP_ADDIU, 6'h0, 16'h0001, 5'd3, 5'd0, 32'd10, 32'd0);
    v.in_valid = 1'b0; v.fv = 2'b01; v.fl = 2'b01; v.fa0 = 5'd3;
    go("invalid", ex(v, 1'b0, 1'b0, 32'h0, 32'h0));

    hold = mk(OP_ADDIU, 6'h0, 16'h0001, 5'd3, 5'd0, 32'd10, 32'd0);
    go("hold_load", ex(hold, 1'b0, 1'b1, 32'd10, 32'd1));
    v = mk(OP_ADDIU, 6'h0, 16'h0002, 5'd4, 5'd0, 32'h20, 32'h0); v.stall_in = 1'b1;
    go("stall1", ex(v, 1'b0, 1'b1, 32'd10, 32'd1));
    v = lu; v.stall_in = 1'b1;
    go("stall2_haz", ex(v, 1'b1, 1'b1, 32'd10, 32'd1));
    v = mk(OP_ORI, 6'h0, 16'h00FF, 5'd5, 5'd0, 32'h30, 32'h0); v.stall_in = 1'b1;
    go("stall3", ex(v, 1'b0, 1'b1, 32'd10, 32'd1));
    v = lu; v.flush = 1'b1;
    go("flush_haz", ex(v, 1'b0, 1'b0, 32'h0, 32'h0));

    go("reload1", ex(hold, 1'b0, 1'b1, 32'd10, 32'd1));
    v = hold; v.flush = 1'b1; v.stall_in = 1'b1;
    go("flush_stall", ex(v, 1'b0, 1'b0, 32'h0, 32'h0));
    go("reload2", ex(hold, 1'b0, 1'b1, 32'd10, 32'd1));
    v = hold; v.stall_in = 1'b1; v.rst = 1'b1;
    go("rst_stall", ex(v, 1'b0, 1'b0, 32'h0, 32'h0));
    v = mk(OP_ADDIU, 6'h0, 16'h7FFF, 5'd3, 5'd0, 32'h40, 32'h0);
    go("after_rst", ex(v, 1'b0, 1'b1, 32'h40, 32'h7FFF));
    v = mk(OP_ADDIU, 6'h0, 16'h7FFF, 5'd3, 5'd0, 32'h40, 32'h0); v.in_valid = 1'b0;
    go("idle", ex(v, 1'b0, 1'b0, 32'h0, 32'h0));

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries still queued, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
